// File: rtl/div_share_arbiter.sv
// div_share_arbiter: round-robin front end sharing one sequential 8-bit divider among NREQ clients.
// Optional macro DIV_ZERO_BYPASS_EN answers zero divisors locally without starting the divider.
module div_share_arbiter #(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned IDW          = 2,
  parameter int unsigned BUSY_TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] req_a,
  input  logic [NREQ*8-1:0] req_b,
  output logic [NREQ-1:0]   gnt,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [7:0]        rsp_q,
  output logic [7:0]        rsp_r,
  output logic              rsp_dz,
  output logic              div_start,
  output logic [7:0]        div_a,
  output logic [7:0]        div_b,
  input  logic              div_busy,
  input  logic [7:0]        div_out
);

  localparam int unsigned CNTW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_CAP_Q,
    S_CAP_R,
    S_RESP
  } state_t;

  state_t          state, state_n;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  wid;
  logic [IDW-1:0]  win;
  logic [IDW:0]    rr_idx;
  logic [NREQ-1:0] win_onehot;
  logic            found;
  logic            bypass;
  logic            load_q;
  logic            cnt_hit;
  logic [CNTW-1:0] cnt;
  logic [7:0]      qreg;
  logic [7:0]      rreg;
  logic [7:0]      slot_a [NREQ];
  logic [7:0]      slot_b [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_slot
    assign slot_a[g] = req_a[8*g +: 8];
    assign slot_b[g] = req_b[8*g +: 8];
  end

  // Scan from rr_ptr upward, wrapping at NREQ (which need not be a power of two).
  always_comb begin
    found      = 1'b0;
    win        = '0;
    rr_idx     = '0;
    win_onehot = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      rr_idx = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (rr_idx >= (IDW+1)'(NREQ)) rr_idx = rr_idx - (IDW+1)'(NREQ);
      if (!found && req[rr_idx[IDW-1:0]]) begin
        found = 1'b1;
        win   = rr_idx[IDW-1:0];
      end
    end
    win_onehot[win] = found;
  end

`ifdef DIV_ZERO_BYPASS_EN
  assign bypass = found && (slot_b[win] == 8'd0);
`else
  assign bypass = 1'b0;
`endif

  assign cnt_hit = (cnt + 1'b1) == CNTW'(BUSY_TIMEOUT);

  // The quotient is only on div_out during the cycle that decides to enter CAP_Q,
  // so qreg loads on that transition and the remainder loads while in CAP_Q.
  always_comb begin
    state_n = state;
    load_q  = 1'b0;
    case (state)
      S_IDLE: begin
        if (found) state_n = bypass ? S_RESP : S_ISSUE;
      end
      S_ISSUE: state_n = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (div_busy) begin
          state_n = S_WAIT_DONE;
        end else if (cnt_hit) begin
          state_n = S_CAP_Q;
          load_q  = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!div_busy) begin
          state_n = S_CAP_Q;
          load_q  = 1'b1;
        end
      end
      S_CAP_Q: state_n = S_CAP_R;
      S_CAP_R: state_n = S_RESP;
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt       <= '0;
      div_start <= 1'b0;
      div_a     <= '0;
      div_b     <= '0;
      wid       <= '0;
      rr_ptr    <= '0;
      cnt       <= '0;
      qreg      <= '0;
      rreg      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_q     <= '0;
      rsp_r     <= '0;
    end else begin
      gnt       <= '0;
      div_start <= 1'b0;
      rsp_valid <= 1'b0;

      if (state == S_IDLE && found) begin
        gnt       <= win_onehot;
        div_a     <= slot_a[win];
        div_b     <= slot_b[win];
        wid       <= win;
        div_start <= !bypass;
        if (bypass) begin
          qreg <= '0;
          rreg <= '0;
        end
      end

      if (state == S_ISSUE)                       cnt <= '0;
      else if (state == S_WAIT_BUSY && !div_busy) cnt <= cnt + 1'b1;

      if (load_q)             qreg <= div_out;
      if (state == S_CAP_Q)   rreg <= div_out;

      if (state == S_RESP) begin
        rsp_valid <= 1'b1;
        rsp_q     <= qreg;
        rsp_r     <= rreg;
        rsp_id    <= wid;
        rr_ptr    <= (wid == IDW'(NREQ - 1)) ? '0 : wid + 1'b1;
      end
    end
  end

`ifdef DIV_ZERO_BYPASS_EN
  logic dz_flag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dz_flag <= 1'b0;
      rsp_dz  <= 1'b0;
    end else begin
      if (state == S_IDLE && found) dz_flag <= bypass;
      if (state == S_RESP)          rsp_dz  <= dz_flag;
    end
  end
`else
  assign rsp_dz = 1'b0;
`endif

endmodule

// File: tb/tb_div_share_arbiter.sv
// tb_div_share_arbiter: scoreboard bench around a behavioural sequential divider,
// with a stub mode that never raises busy to exercise the busy timeout.
module tb_div_share_arbiter;

  localparam int unsigned NREQ         = 4;
  localparam int unsigned IDW          = 2;
  localparam int unsigned BUSY_TIMEOUT = 4;
  localparam int unsigned DIV_LAT      = 8;
  localparam int unsigned LAT_REAL     = 1 + 1 + DIV_LAT + 3;
  localparam int unsigned LAT_STUB     = 1 + BUSY_TIMEOUT + 3;
`ifdef DIV_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*8-1:0] req_a;
  logic [NREQ*8-1:0] req_b;
  logic [NREQ-1:0]   gnt;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_q;
  logic [7:0]        rsp_r;
  logic              rsp_dz;
  logic              div_start;
  logic [7:0]        div_a;
  logic [7:0]        div_b;
  logic              div_busy;
  logic [7:0]        div_out;

  div_share_arbiter #(
    .NREQ(NREQ),
    .IDW(IDW),
    .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .req_a(req_a),
    .req_b(req_b),
    .gnt(gnt),
    .rsp_valid(rsp_valid),
    .rsp_id(rsp_id),
    .rsp_q(rsp_q),
    .rsp_r(rsp_r),
    .rsp_dz(rsp_dz),
    .div_start(div_start),
    .div_a(div_a),
    .div_b(div_b),
    .div_busy(div_busy),
    .div_out(div_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int unsigned id;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        dz;
    int unsigned lat;
  } rsp_t;

  rsp_t        rsp_exp [$];
  int unsigned gnt_exp [$];
  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc = 0;
  int unsigned gnt_cyc = 0;
  int unsigned nstart = 0;
  bit          inflight = 1'b0;
  bit          stub_mode = 1'b0;
  int unsigned posted [NREQ] = '{default: 0};
  int unsigned served [NREQ] = '{default: 0};

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Requester i holds req until the monitor has seen its grant.
  always_comb begin
    req = '0;
    for (int i = 0; i < NREQ; i++) req[i] = (posted[i] != served[i]);
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural divider: busy for DIV_LAT cycles, then quotient, then remainder.
  logic [7:0]  dq;
  logic [7:0]  dr;
  logic [1:0]  dph;
  int unsigned dcnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      div_busy <= 1'b0;
      div_out  <= 8'd0;
      dph      <= 2'd0;
      dcnt     <= 0;
      dq       <= 8'd0;
      dr       <= 8'd0;
    end else if (div_start) begin
      dph <= 2'd1;
      if (stub_mode) begin
        div_out <= 8'hAA;
        dcnt    <= 0;
      end else begin
        div_busy <= 1'b1;
        dcnt     <= DIV_LAT - 1;
        dq       <= (div_b == 8'd0) ? 8'd0 : div_a / div_b;
        dr       <= (div_b == 8'd0) ? 8'd0 : div_a % div_b;
      end
    end else if (dph == 2'd1) begin
      if (stub_mode) begin
        if (dcnt == BUSY_TIMEOUT - 1) begin
          div_out <= 8'h55;
          dph     <= 2'd0;
        end else begin
          dcnt <= dcnt + 1;
        end
      end else if (dcnt == 0) begin
        div_busy <= 1'b0;
        div_out  <= dq;
        dph      <= 2'd2;
      end else begin
        dcnt <= dcnt - 1;
      end
    end else if (dph == 2'd2) begin
      div_out <= dr;
      dph     <= 2'd0;
    end
  end

  rsp_t        mon_e;
  int unsigned mon_g;

  always @(negedge clk) begin
    if (reset) begin
      inflight = 1'b0;
      for (int i = 0; i < NREQ; i++) served[i] = posted[i];
    end else begin
      if (div_start) nstart++;
      if (gnt != '0) begin
        check("overlap", 64'(inflight), 64'(0));
        if (gnt_exp.size() == 0) begin
          check("gnt_unexpected", 64'(gnt), 64'(0));
        end else begin
          mon_g = gnt_exp.pop_front();
          check("gnt", 64'(gnt), 64'(1) << mon_g);
        end
        for (int i = 0; i < NREQ; i++) if (gnt[i]) served[i] = posted[i];
        inflight = 1'b1;
        gnt_cyc  = cyc;
      end
      if (rsp_valid) begin
        inflight = 1'b0;
        if (rsp_exp.size() == 0) begin
          check("rsp_unexpected", 64'(rsp_valid), 64'(0));
        end else begin
          mon_e = rsp_exp.pop_front();
          check("rsp_id", 64'(rsp_id), 64'(mon_e.id));
          check("rsp_q", 64'(rsp_q), 64'(mon_e.q));
          check("rsp_r", 64'(rsp_r), 64'(mon_e.r));
          check("rsp_dz", 64'(rsp_dz), 64'(mon_e.dz));
          if (mon_e.lat != 0) check("latency", 64'(cyc - gnt_cyc), 64'(mon_e.lat));
        end
      end
    end
  end

  task automatic post(input int unsigned id, input logic [7:0] a, input logic [7:0] b);
    req_a[id*8 +: 8] = a;
    req_b[id*8 +: 8] = b;
    posted[id]++;
  endtask

  task automatic expect_op(input int unsigned id, input logic [7:0] a, input logic [7:0] b);
    rsp_t e;
    e.id  = id;
    e.lat = LAT_REAL;
    e.dz  = 1'b0;
    if (b == 8'd0) begin
      e.q = 8'd0;
      e.r = 8'd0;
      if (BYP) begin
        e.dz  = 1'b1;
        e.lat = 0;
      end
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    gnt_exp.push_back(id);
    rsp_exp.push_back(e);
  endtask

  task automatic drain(input int unsigned maxc);
    int unsigned n;
    n = 0;
    while ((rsp_exp.size() != 0 || gnt_exp.size() != 0) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (n >= maxc) check("drain_timeout", 64'(rsp_exp.size() + gnt_exp.size()), 64'(0));
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [63:0] outs();
    return 64'({gnt, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dz, div_start, div_a, div_b});
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: no finish after %0d checks", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned n;
    int unsigned s0;
    int unsigned rid;
    logic [7:0]  ra;
    logic [7:0]  rb;
    rsp_t        se;

    reset = 1'b1;
    req_a = '0;
    req_b = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    // Four simultaneous requests from rr_ptr=0.
    expect_op(0, 8'd17,  8'd8);
    expect_op(1, 8'd12,  8'd15);
    expect_op(2, 8'd0,   8'd13);
    expect_op(3, 8'd255, 8'd15);
    post(0, 8'd17, 8'd8);
    post(1, 8'd12, 8'd15);
    post(2, 8'd0, 8'd13);
    post(3, 8'd255, 8'd15);
    drain(200);
    check("hold_q", 64'(rsp_q), 64'(17));
    check("hold_r", 64'(rsp_r), 64'(0));
    check("hold_id", 64'(rsp_id), 64'(3));

    // Single request.
    expect_op(0, 8'd17, 8'd8);
    post(0, 8'd17, 8'd8);
    drain(100);

    // Round robin: serve 1, then req=1011 with rr_ptr=2 -> 3, 0, 1.
    expect_op(1, 8'd13, 8'd5);
    post(1, 8'd13, 8'd5);
    drain(100);
    expect_op(3, 8'd200, 8'd9);
    expect_op(0, 8'd99,  8'd10);
    expect_op(1, 8'd7,   8'd7);
    post(0, 8'd99, 8'd10);
    post(1, 8'd7, 8'd7);
    post(3, 8'd200, 8'd9);
    drain(200);

    // Reset in the middle of a divide: no response, rr_ptr back to 0.
    gnt_exp.push_back(2);
    post(2, 8'd213, 8'd8);
    n = 0;
    while (gnt_exp.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("midop_gnt_timeout", 64'(gnt_exp.size()), 64'(0));
    repeat (6) @(negedge clk);
    #2 reset = 1'b1;
    #1 check("reset_async", outs(), 64'(0));
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("reset_no_result", 64'(rsp_q), 64'(0));
    expect_op(1, 8'd13,  8'd5);
    expect_op(3, 8'd100, 8'd7);
    post(1, 8'd13, 8'd5);
    post(3, 8'd100, 8'd7);
    drain(200);

    // Zero divisor.
    s0 = nstart;
    expect_op(0, 8'd40, 8'd0);
    post(0, 8'd40, 8'd0);
    drain(100);
    check("zero_div_starts", 64'(nstart - s0), BYP ? 64'(0) : 64'(1));

    // Random single transactions.
    for (int k = 0; k < 8; k++) begin
      rid = $urandom_range(0, NREQ - 1);
      ra  = 8'($urandom_range(0, 255));
      rb  = (k == 3) ? 8'd0 : 8'($urandom_range(0, 255));
      expect_op(rid, ra, rb);
      post(rid, ra, rb);
      drain(100);
    end

    // Divider that never raises busy: timeout path.
    stub_mode = 1'b1;
    se.id  = 2;
    se.q   = 8'hAA;
    se.r   = 8'h55;
    se.dz  = 1'b0;
    se.lat = LAT_STUB;
    gnt_exp.push_back(2);
    rsp_exp.push_back(se);
    post(2, 8'd5, 8'd3);
    drain(100);
    stub_mode = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
